// File: rtl/instr_encoder.sv
// instr_encoder: encodes field-level instruction requests into MIPS-subset words
// and streams them through a FIFO to consecutive instruction-memory addresses.
module instr_encoder #(
   parameter int DEPTH     = 4,
   parameter int ADDR_W    = 8,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [2:0]        req_kind,
   input  logic [4:0]        req_rs,
   input  logic [4:0]        req_rt,
   input  logic [4:0]        req_rd,
   input  logic [5:0]        req_funct,
   input  logic [15:0]       req_imm,
   input  logic [25:0]       req_target,
   output logic              wr_valid,
   input  logic              wr_ready,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   wr_count,
   input  logic              clear
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [1:0] RUN = 2'd0, DRAIN = 2'd1, DONE = 2'd2;
   logic [1:0]        state;
   logic [31:0]       mem [DEPTH];
   logic [PW-1:0]     rp, wp;
   logic [PW:0]       cnt;
   logic [31:0]       enc;
   logic [ADDR_W-1:0] addr;
   logic              full, empty, acc, push, pop;
   always_comb begin
      enc = req_kind == 3'd0 ? {6'h00, req_rs, req_rt, req_rd, 5'd0, req_funct} :
            req_kind == 3'd1 ? {6'h08, req_rs, req_rt, req_imm} :
            req_kind == 3'd2 ? {6'h23, req_rs, req_rt, req_imm} :
            req_kind == 3'd3 ? {6'h2B, req_rs, req_rt, req_imm} :
            req_kind == 3'd4 ? {6'h04, req_rs, req_rt, req_imm} :
            req_kind == 3'd5 ? {6'h02, req_target} : {6'h3F, 26'd0};
   end
   assign full      = cnt == (PW+1)'(DEPTH);
   assign empty     = cnt == '0;
   assign req_ready = state == RUN && !full;
   assign acc       = req_valid && req_ready;
   assign push      = acc && req_kind != 3'd7;
   assign wr_valid  = !empty;
   assign pop       = wr_valid && wr_ready;
   assign wr_data   = empty ? '0 : mem[rp];
   assign wr_addr   = addr;
   assign done      = state == DONE;
   always_ff @(posedge clk) begin
      if (push) mem[wp] <= enc;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= RUN;
         rp       <= '0;
         wp       <= '0;
         cnt      <= '0;
         addr     <= ADDR_W'(BASE_ADDR);
         err      <= 1'b0;
         wr_count <= '0;
      end else begin
         if (push) wp <= wp + PW'(1);
         if (pop) rp <= rp + PW'(1);
         cnt <= cnt + (PW+1)'(push) - (PW+1)'(pop);
         if (pop) addr <= addr + ADDR_W'(1);
         if (pop && wr_count != '1) wr_count <= wr_count + (ADDR_W+1)'(1);
         if (acc && req_kind == 3'd7) err <= 1'b1;
         if (state == RUN && push && req_kind == 3'd6) state <= DRAIN;
         if (state == DRAIN && pop && cnt == (PW+1)'(1)) state <= DONE;
         // restart only from DONE, where the FIFO is already empty
         if (state == DONE && clear) begin
            state    <= RUN;
            addr     <= ADDR_W'(BASE_ADDR);
            err      <= 1'b0;
            wr_count <= '0;
         end
      end
   end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: table-driven and scoreboard checks of instr_encoder, with a
// second ADDR_W=2 instance sharing the stimulus for address wrap and count saturation.
module tb_instr_encoder;
   logic        clk = 0, rst = 0, req_valid = 0, wr_ready = 0, clear = 0;
   logic [2:0]  req_kind = 0;
   logic [4:0]  req_rs = 0, req_rt = 0, req_rd = 0;
   logic [5:0]  req_funct = 0;
   logic [15:0] req_imm = 0;
   logic [25:0] req_target = 0;
   logic        req_ready, wr_valid, done, err;
   logic [7:0]  wr_addr;
   logic [31:0] wr_data;
   logic [8:0]  wr_count;
   logic        req_ready_s, wr_valid_s, done_s, err_s;
   logic [1:0]  wr_addr_s;
   logic [31:0] wr_data_s;
   logic [2:0]  wr_count_s;

   instr_encoder #(.DEPTH(4), .ADDR_W(8), .BASE_ADDR(0)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
      .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_funct(req_funct), .req_imm(req_imm),
      .req_target(req_target), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
      .wr_data(wr_data), .done(done), .err(err), .wr_count(wr_count), .clear(clear));

   instr_encoder #(.DEPTH(4), .ADDR_W(2), .BASE_ADDR(0)) dut_s (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_s), .req_kind(req_kind),
      .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_funct(req_funct), .req_imm(req_imm),
      .req_target(req_target), .wr_valid(wr_valid_s), .wr_ready(wr_ready), .wr_addr(wr_addr_s),
      .wr_data(wr_data_s), .done(done_s), .err(err_s), .wr_count(wr_count_s), .clear(clear));

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  k;
      logic [4:0]  rs, rt, rd;
      logic [5:0]  fn;
      logic [15:0] imm;
      logic [25:0] tg;
      logic [31:0] exp;
   } vec_t;
   vec_t tv[7];

   int          n_cmp = 0, n_bad = 0;
   logic [31:0] q[$];
   logic [7:0]  exp_addr = 0;
   logic [1:0]  exp_addr_s = 0;
   logic        prev_stall = 0;
   logic [7:0]  prev_addr;
   logic [31:0] prev_data;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // scoreboard: a handshake seen at this negedge completes on the next posedge
   always @(negedge clk) begin
      if (wr_valid && !wr_ready && prev_stall) begin
         check("stall_addr", 64'(wr_addr), 64'(prev_addr));
         check("stall_data", 64'(wr_data), 64'(prev_data));
      end
      prev_stall = wr_valid && !wr_ready;
      prev_addr  = wr_addr;
      prev_data  = wr_data;
      if (wr_valid && wr_ready) begin
         if (q.size() == 0) check("unexpected_write", 64'(wr_data), 64'hDEAD);
         else begin
            check("wr_data", 64'(wr_data), 64'(q.pop_front()));
            check("wr_addr", 64'(wr_addr), 64'(exp_addr));
         end
         exp_addr++;
      end
      if (wr_valid_s && wr_ready) begin
         check("wr_addr_s", 64'(wr_addr_s), 64'(exp_addr_s));
         exp_addr_s++;
      end
   end

   task automatic send(input logic [2:0] k, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [5:0] fn, input logic [15:0] imm,
                       input logic [25:0] tg, input logic [31:0] exp);
      logic ok = 0;
      req_kind = k; req_rs = rs; req_rt = rt; req_rd = rd;
      req_funct = fn; req_imm = imm; req_target = tg; req_valid = 1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (req_ready) begin ok = 1; break; end
      end
      if (!ok) check("accept_timeout", 0, 1);
      else if (k != 3'd7) q.push_back(exp);
      @(posedge clk); #1;
      req_valid = 0;
   endtask

   task automatic send_v(input vec_t v);
      send(v.k, v.rs, v.rt, v.rd, v.fn, v.imm, v.tg, v.exp);
   endtask

   task automatic send_r(input int i);
      logic [4:0] a = 5'(i), b = 5'(i + 1), c = 5'(i + 2);
      send(3'd0, a, b, c, 6'h20, 16'h0, 26'h0,
           (32'(a) << 21) | (32'(b) << 16) | (32'(c) << 11) | 32'h20);
   endtask

   task automatic drain();
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         if (q.size() == 0) break;
      end
      check("drain_empty", 64'(q.size()), 0);
   endtask

   task automatic do_reset();
      rst = 0;
      #2;
      check("rst_wr_valid", 64'(wr_valid), 0);
      check("rst_done", 64'(done), 0);
      check("rst_err", 64'(err), 0);
      check("rst_wr_count", 64'(wr_count), 0);
      check("rst_req_ready", 64'(req_ready), 1);
      check("rst_wr_addr", 64'(wr_addr), 0);
      check("rst_wr_data", 64'(wr_data), 0);
      q.delete();
      exp_addr = 0; exp_addr_s = 0;
      @(negedge clk);
      rst = 1;
      @(posedge clk); #1;
   endtask

   task automatic do_clear();
      clear = 1;
      @(posedge clk); #1;
      clear = 0;
      exp_addr = 0; exp_addr_s = 0;
   endtask

   initial begin
      tv[0] = '{3'd1, 5'd1, 5'd2, 5'd0, 6'h00, 16'h0005, 26'h0, 32'h20220005};
      tv[1] = '{3'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0000, 26'h0, 32'h00221820};
      tv[2] = '{3'd2, 5'd0, 5'd4, 5'd0, 6'h00, 16'h0008, 26'h0, 32'h8C040008};
      tv[3] = '{3'd3, 5'd0, 5'd4, 5'd0, 6'h00, 16'h000C, 26'h0, 32'hAC04000C};
      tv[4] = '{3'd4, 5'd1, 5'd2, 5'd0, 6'h00, 16'hFFFF, 26'h0, 32'h1022FFFF};
      tv[5] = '{3'd5, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0000, 26'h10, 32'h08000010};
      tv[6] = '{3'd6, 5'd7, 5'd7, 5'd7, 6'h3F, 16'h1234, 26'h55, 32'hFC000000};

      do_reset();
      wr_ready = 1;
      for (int i = 0; i < 4; i++) send_v(tv[i]);
      drain();
      check("count_4", 64'(wr_count), 4);

      do_reset();
      for (int i = 4; i < 7; i++) send_v(tv[i]);
      check("ready_after_hlt", 64'(req_ready), 0);
      drain();
      check("done_after_hlt", 64'(done), 1);
      check("count_3", 64'(wr_count), 3);
      do_clear();
      check("clr_done", 64'(done), 0);
      check("clr_ready", 64'(req_ready), 1);
      check("clr_count", 64'(wr_count), 0);
      check("clr_addr", 64'(wr_addr), 0);

      do_reset();
      wr_ready = 0;
      for (int i = 0; i < 4; i++)
         send(3'd1, 5'(i), 5'(i + 8), 5'd0, 6'h0, 16'(i * 3), 26'h0,
              32'h20000000 + (i << 21) + ((i + 8) << 16) + i * 3);
      check("full_ready", 64'(req_ready), 0);
      fork
         send(3'd1, 5'd4, 5'd12, 5'd0, 6'h0, 16'd12, 26'h0, 32'h208C000C);
         begin
            repeat (3) @(posedge clk);
            #1 wr_ready = 1;
            @(negedge clk);
            check("full_pop_refuse", 64'(req_ready), 0);
         end
      join
      drain();
      check("count_5", 64'(wr_count), 5);

      do_reset();
      send_v(tv[0]);
      send(3'd7, 5'd9, 5'd9, 5'd9, 6'h0, 16'h9, 26'h9, 32'h0);
      check("err_set", 64'(err), 1);
      send(3'd1, 5'd3, 5'd4, 5'd0, 6'h0, 16'h0010, 26'h0, 32'h20640010);
      drain();
      check("count_2", 64'(wr_count), 2);
      send_v(tv[6]);
      drain();
      check("err_hold", 64'(err), 1);
      check("done_ill", 64'(done), 1);
      do_clear();
      check("err_clr", 64'(err), 0);

      wr_ready = 0;
      for (int i = 0; i < 3; i++) send_r(i);
      check("queued_valid", 64'(wr_valid), 1);
      rst = 0;
      #1;
      check("rst_async_valid", 64'(wr_valid), 0);
      check("rst_async_data", 64'(wr_data), 0);
      q.delete();
      exp_addr = 0; exp_addr_s = 0;
      #3 rst = 1;
      @(posedge clk); #1;
      wr_ready = 1;
      send_r(5);
      drain();
      clear = 1;
      @(posedge clk); #1;
      clear = 0;
      check("run_clear_ready", 64'(req_ready), 1);
      check("run_clear_count", 64'(wr_count), 1);
      send_r(6);
      drain();
      check("run_clear_addr", 64'(wr_addr), 2);

      do_reset();
      for (int i = 0; i < 5; i++) send_r(i);
      send_v(tv[6]);
      drain();
      check("wrap_count_s", 64'(wr_count_s), 6);
      check("wrap_done_s", 64'(done_s), 1);
      check("wrap_addr_s", 64'(wr_addr_s), 2);
      do_clear();
      for (int i = 0; i < 8; i++) send_r(i);
      send_v(tv[6]);
      drain();
      check("sat_count_s", 64'(wr_count_s), 7);
      check("count_9", 64'(wr_count), 9);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
